// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: req/gnt/valid memory handshake bundle shared by masters and the memory side
interface mem_port_arbiter_if;
  logic        req;
  logic        gnt;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        valid;
  logic        err;
  modport master (output req, wr, addr, wdata, be, input gnt, rdata, valid, err);
  modport slave  (input req, wr, addr, wdata, be, output gnt, rdata, valid, err);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data masters with in-order response routing
module mem_port_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  instr,
  mem_port_arbiter_if.slave  data,
  mem_port_arbiter_if.master mem,
  output logic               spurious_rsp
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                 state;
  logic                   locked, last, sel, sel_req, full, empty, head, push, pop, unused_ok;
  logic [OUTSTANDING-1:0] ids;
  logic [PW-1:0]          wptr, rptr;
  logic [CW-1:0]          count;
  // Held selection wins while a request waits for its grant; otherwise round-robin on contention
  always_comb begin
    sel = state == LOCKED ? locked : (instr.req & data.req) ? ~last : data.req;
    sel_req = sel ? data.req : instr.req;
  end
  assign full  = count == CW'(OUTSTANDING);
  assign empty = count == '0;
  assign head  = ids[rptr];
  assign push  = mem.req & mem.gnt;
  assign pop   = mem.valid & ~empty;
  assign mem.req   = sel_req & ~full;
  assign mem.wr    = sel_req & sel & data.wr;
  assign mem.addr  = sel_req ? (sel ? data.addr : instr.addr) : '0;
  assign mem.wdata = (sel_req & sel) ? data.wdata : '0;
  assign mem.be    = sel_req ? (sel ? data.be : 4'hF) : '0;
  assign instr.gnt   = mem.gnt & mem.req & ~sel;
  assign data.gnt    = mem.gnt & mem.req & sel;
  assign instr.valid = mem.valid & ~head & ~empty;
  assign data.valid  = mem.valid & head & ~empty;
  assign instr.rdata = mem.rdata;
  assign data.rdata  = mem.rdata;
  assign instr.err   = mem.err;
  assign data.err    = mem.err;
  assign unused_ok   = ^{instr.wr, instr.wdata, instr.be};
  // Lock FSM and round-robin history: last follows every acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      locked <= 1'b0;
      last <= 1'b1;
    end else begin
      if (push) last <= sel;
      if (state == IDLE && mem.req && !mem.gnt) begin
        state <= LOCKED;
        locked <= sel;
      end else if (state == LOCKED && (mem.gnt || !mem.req)) state <= IDLE;
    end
  end
  // Master-ID storage for outstanding transactions
  always_ff @(posedge clk) begin
    if (push) ids[wptr] <= sel;
  end
  // Queue pointers, occupancy and sticky spurious-response flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      spurious_rsp <= 1'b0;
    end else begin
      if (push) wptr <= wptr == PW'(OUTSTANDING - 1) ? '0 : wptr + PW'(1);
      if (pop) rptr <= rptr == PW'(OUTSTANDING - 1) ? '0 : rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (mem.valid && empty) spurious_rsp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan scenarios plus random traffic against a queue-based reference model
module tb_mem_port_arbiter;
  localparam int OUT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spurious_rsp;
  int checks = 0;
  int failures = 0;
  mem_port_arbiter_if instr_bus ();
  mem_port_arbiter_if data_bus ();
  mem_port_arbiter_if mem_bus ();

  mem_port_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr_bus),
    .data(data_bus),
    .mem(mem_bus),
    .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  int q[$];
  bit last, lk, lk_who, spur;
  bit m_ig, m_dg;
  logic o_ig, o_dg, o_iv, o_dv, o_derr, o_mreq, o_sp;
  logic [31:0] o_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = 1'b1;
    lk = 1'b0;
    lk_who = 1'b0;
    spur = 1'b0;
  endtask

  task automatic do_reset();
    instr_bus.req = 0; instr_bus.wr = 0; instr_bus.addr = 0; instr_bus.wdata = 0; instr_bus.be = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.addr = 0; data_bus.wdata = 0; data_bus.be = 0;
    mem_bus.gnt = 0; mem_bus.valid = 0; mem_bus.rdata = 0; mem_bus.err = 0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called just after a negedge with inputs applied; checks, advances model, moves to next negedge
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
                     input logic mg, input logic mv, input logic [31:0] md, input logic me);
    bit who, rq, mreq, iv, dv, ewr;
    logic [31:0] ea, ewd;
    logic [3:0] eb;
    instr_bus.req = ir; instr_bus.addr = ia; instr_bus.wr = 0; instr_bus.wdata = 0; instr_bus.be = 0;
    data_bus.req = dr; data_bus.wr = dw; data_bus.addr = da; data_bus.wdata = dd; data_bus.be = db;
    mem_bus.gnt = mg; mem_bus.valid = mv; mem_bus.rdata = md; mem_bus.err = me;
    #1;
    who = lk ? lk_who : (ir && dr) ? !last : dr;
    rq = who ? dr : ir;
    mreq = rq && q.size() < OUT;
    ea = !rq ? 32'h0 : who ? da : ia;
    ewr = rq && who && dw;
    eb = !rq ? 4'h0 : who ? db : 4'hF;
    ewd = (rq && who) ? dd : 32'h0;
    m_ig = mg && mreq && !who;
    m_dg = mg && mreq && who;
    iv = mv && q.size() > 0 && q[0] == 0;
    dv = mv && q.size() > 0 && q[0] == 1;
    o_ig = instr_bus.gnt; o_dg = data_bus.gnt; o_iv = instr_bus.valid; o_dv = data_bus.valid;
    o_derr = data_bus.err; o_mreq = mem_bus.req; o_sp = spurious_rsp; o_addr = mem_bus.addr;
    check("ctl", {25'd0, mem_bus.req, mem_bus.wr, instr_bus.gnt, data_bus.gnt, instr_bus.valid, data_bus.valid, spurious_rsp},
          {25'd0, mreq, ewr, m_ig, m_dg, iv, dv, spur});
    check("addr", mem_bus.addr, ea);
    check("be", {28'd0, mem_bus.be}, {28'd0, eb});
    check("wdata", mem_bus.wdata, ewd);
    check("irdata", instr_bus.rdata, md);
    check("drdata", data_bus.rdata, md);
    check("err", {30'd0, instr_bus.err, data_bus.err}, {30'd0, me, me});
    if (mv && q.size() == 0) spur = 1'b1;
    if (mv && q.size() > 0) void'(q.pop_front());
    if (mreq && mg) begin
      q.push_back(who);
      last = who;
    end
    if (lk) begin
      if (mg || !mreq) lk = 1'b0;
    end else if (mreq && !mg) begin
      lk = 1'b1;
      lk_who = who;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] h_ig, h_dg, h_iv, h_dv, h_de, h_mr;
    logic ir, dr, dw, mg, mv, me;
    logic [31:0] ia, da, dd, md;
    logic [3:0] db;
    do_reset();
    check("rst_mreq", {31'd0, mem_bus.req}, 32'd0);
    check("rst_spur", {31'd0, spurious_rsp}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fetch only
    h_ig = 0; h_dv = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(k < 3, 32'(k * 4), 0, 0, 0, 0, 0, 1, k > 0, 32'h100 + 32'(k), 0);
      h_ig = {h_ig[6:0], o_ig};
      h_dv = {h_dv[6:0], o_dv};
    end
    check("fetch_gnt", {24'd0, h_ig}, 32'h0E);
    check("fetch_dv", {24'd0, h_dv}, 32'h00);
    // contention after reset
    do_reset();
    h_ig = 0; h_dg = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'h40, 1, 1, 32'h80, 32'hdeadbeef, 4'b0011, 1, k > 0, 32'h5a, 0);
      h_ig = {h_ig[6:0], o_ig};
      h_dg = {h_dg[6:0], o_dg};
    end
    check("cont_ig", {24'd0, h_ig}, 32'h0A);
    check("cont_dg", {24'd0, h_dg}, 32'h05);
    // lock
    do_reset();
    h_ig = 0; h_dg = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(k >= 1, 32'h3000, k < 4, 0, 32'h2000, 0, 4'hF, k >= 3, 0, 0, 0);
      h_ig = {h_ig[6:0], o_ig};
      h_dg = {h_dg[6:0], o_dg};
      if (k == 2) check("lock_addr", o_addr, 32'h2000);
    end
    check("lock_ig", {24'd0, h_ig}, 32'h01);
    check("lock_dg", {24'd0, h_dg}, 32'h02);
    // full queue
    do_reset();
    h_mr = 0; h_iv = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 32'h100, 0, 0, 0, 0, 0, 1, k == 3, 32'h77, 0);
      h_mr = {h_mr[6:0], o_mreq};
      h_iv = {h_iv[6:0], o_iv};
    end
    check("full_mreq", {24'd0, h_mr}, 32'h19);
    check("full_iv", {24'd0, h_iv}, 32'h02);
    // mixed routing with error
    do_reset();
    h_iv = 0; h_dv = 0; h_de = 0;
    cyc(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h20, 0, 4'hF, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(k < 2, 32'h14, 0, 0, 0, 0, 0, 1, 1, 32'hA0 + 32'(k), k == 1);
      h_iv = {h_iv[6:0], o_iv};
      h_dv = {h_dv[6:0], o_dv};
      h_de = {h_de[6:0], o_dv & o_derr};
    end
    check("mix_iv", {24'd0, h_iv}, 32'h05);
    check("mix_dv", {24'd0, h_dv}, 32'h02);
    check("mix_derr", {24'd0, h_de}, 32'h02);
    // spurious response and reset flush
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0);
    check("spur_noval", {30'd0, o_iv, o_dv}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("spur_set", {31'd0, o_sp}, 32'd1);
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_flush", {30'd0, o_sp, o_mreq}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 0);
    check("stale_noval", {30'd0, o_iv, o_dv}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("stale_spur", {31'd0, o_sp}, 32'd1);
    // random traffic
    do_reset();
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dd = 0; db = 0;
    m_ig = 0; m_dg = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!ir || m_ig) begin
        ir = $urandom_range(0, 2) != 0;
        ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!dr || m_dg) begin
        dr = $urandom_range(0, 2) != 0;
        dw = $urandom_range(0, 1) != 0;
        da = $urandom;
        dd = $urandom;
        db = 4'($urandom);
      end
      mg = $urandom_range(0, 3) != 0;
      mv = q.size() > 0 && $urandom_range(0, 2) != 0;
      md = $urandom;
      me = $urandom_range(0, 7) == 0;
      cyc(ir, ia, dr, dw, da, dd, db, mg, mv, md, me);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-to-one arbiter that shares a single memory port between the instruction-fetch and data ports of `riscv_core`. It sits between the core and a single-ported memory model or SRAM and uses the same req/gnt/valid handshake on both sides. Contention is resolved round-robin. An in-order outstanding-transaction queue routes each read/write response back to the master that issued it.

## Interface
- `OUTSTANDING`, 2: maximum accepted-but-unanswered transactions (1..8).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_req` in 1; `instr_addr` in 32: fetch request from the core. Always a read.
- `instr_gnt` out 1; `instr_rdata` out 32; `instr_valid` out 1; `instr_err` out 1: fetch grant and response.
- `data_req` in 1; `data_wr` in 1; `data_addr` in 32; `data_wdata` in 32; `data_be` in 4: data request from the core.
- `data_gnt` out 1; `data_rdata` out 32; `data_valid` out 1; `data_error` out 1: data grant and response.
- `mem_req` out 1; `mem_wr` out 1; `mem_addr` out 32; `mem_wdata` out 32; `mem_be` out 4: downstream request.
- `mem_gnt` in 1; `mem_rdata` in 32; `mem_valid` in 1; `mem_err` in 1: downstream grant and response.
- `spurious_rsp` out 1: sticky flag, set by `mem_valid` while nothing is outstanding.

## Operation
- Protocol, both sides:
  - A request is accepted in the cycle where req and gnt are both high.
  - After acceptance, exactly one valid pulse is returned, in order.
  - The memory never returns valid in the same cycle as the grant of that transaction.
- Selection (`sel`: 0 = instr, 1 = data):
  - Only one master requests: select it.
  - Both request: select the master not granted last. The `last` register resets to data, so instr wins the first contention after reset.
- Lock:
  - Once `mem_req` is asserted for a master and not yet granted, `sel` is held in a `locked` register until `mem_gnt`.
  - A newly arriving request from the other master does not switch the selection.
  - States: IDLE (no pending mem_req) -> LOCKED (mem_req high, no gnt) -> IDLE on gnt. The transition to LOCKED happens only when mem_req is high, mem_gnt is low, and the queue is not full.
- Request mux:
  - `mem_req` = selected req AND NOT queue full.
  - `mem_addr`, `mem_wr`, `mem_wdata`, `mem_be` come from the selected master.
  - When instr is selected: `mem_wr` = 0, `mem_be` = 4'hF, `mem_wdata` = 0.
  - When neither master requests, all mem outputs are 0.
- Grant:
  - `instr_gnt` = `mem_gnt & mem_req & ~sel`.
  - `data_gnt` = `mem_gnt & mem_req & sel`.
  - Combinational; no extra cycle.
- Queue:
  - FIFO of 1-bit master IDs, depth `OUTSTANDING`, plus a count register of width clog2(OUTSTANDING+1).
  - Push `sel` on acceptance. Pop on `mem_valid`.
  - Simultaneous push and pop: count unchanged; read and write pointers both advance.
  - Full: `mem_req` forced low. A pop in the same cycle does not unblock it; the request issues the next cycle.
- Response routing (combinational from `mem_valid`):
  - The head ID selects the destination: `instr_valid` = `mem_valid & ~head & ~empty`, `data_valid` = `mem_valid & head & ~empty`.
  - `rdata` and err are forwarded to both masters unqualified; each master samples only on its own valid.
  - `mem_valid` while empty: no valid is forwarded, no pop, and `spurious_rsp` is set until reset.
- `last` updates to `sel` on every acceptance.

## Timing
- Reset values:
  - Registers: count 0, pointers 0, last = data, locked 0, `spurious_rsp` 0.
  - Outputs: all grants and valids 0; `mem_req` 0.
- Reset mid-transaction: the queue is flushed. Responses for transactions in flight before reset are treated as spurious, and memory must be reset together with the arbiter.
- Latency:
  - Request to `mem_req`: 0 cycles.
  - `mem_gnt` to master gnt: 0 cycles.
  - `mem_valid` to master valid: 0 cycles.
- Throughput: one acceptance per cycle while the queue is not full.
- Back-to-back grants from the same master are allowed when the other master is idle.

## Test plan
- Fetch only: instr_req with addr 0x0, 0x4, 0x8 held, mem_gnt=1, and valids returned one cycle later -> three instr_gnt pulses on consecutive cycles, instr_valid in order with matching rdata, and data_valid never asserts.
- Contention after reset:
  - instr_req and data_req both high at the same time with mem_gnt=1 -> grant order instr, data, instr, data.
  - mem_wr/mem_be follow the selected master; data_be 4'b0011 appears on mem_be in data cycles only.
- Lock: data_req with mem_gnt=0 for 3 cycles, and instr_req rising during the wait -> mem_addr stays the data address until mem_gnt, then the next acceptance goes to instr.
- Full queue with OUTSTANDING=2: two acceptances and no valid -> mem_req drops in the third cycle. A valid in cycle 4 routes to the first master; mem_req reasserts in cycle 5.
- Mixed routing: accept instr, data, instr, then mem_valid pulses with mem_err=1 on the second -> instr_valid, then data_valid with data_error=1, then instr_valid.
- Spurious response and reset: mem_valid with nothing outstanding -> no master valid, and spurious_rsp=1 until reset. Asserting reset with 2 outstanding -> count 0 and all outputs 0 the next cycle.
